alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit ALU datapath (bitwise OR/AND/XOR, add/sub units).
- Captures the combinational ALU result plus carry/overflow, derives zero/negative flags, and presents them to the consumer through a valid/ready interface.
- A 2-entry skid buffer lets the upstream ALU keep issuing while the consumer stalls for one cycle, with no combinational ready path.

Parameters:
- WIDTH, 16, result data width in bits; must be 2 or greater.
- OPW, 4, width of the ALU opcode tag carried with each result.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered (no comb path from out_ready).
- in_data  input  WIDTH  ALU result.
- in_op  input  OPW  opcode that produced in_data.
- in_carry  input  1  carry-out from adder/subtractor; 0 for logic ops.
- in_ovf  input  1  signed overflow from adder/subtractor; 0 for logic ops.
- out_valid  output  1  output holds a valid result.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  registered result.
- out_op  output  OPW  registered opcode tag.
- out_flags  output  4  {negative, zero, carry, overflow}.
- sticky_clr  input  1  clears sticky overflow (only used with ALU_STICKY_OVF_EN).
- sticky_ovf  output  1  sticky overflow (tied 0 without macro).

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_data=0, out_op=0, out_flags=0, sticky_ovf=0, skid entry invalid, state EMPTY.
- Flags computed at capture from in_data: zero = (in_data==0); negative = in_data[WIDTH-1]; carry = in_carry; overflow = in_ovf. Flags travel with their data through both entries.
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- States and transitions:
  - EMPTY: input transfer loads main reg -> ONE.
  - ONE: output transfer only -> EMPTY.
  - ONE: input transfer only -> FULL, with the new beat in the skid reg and in_ready=0 next cycle.
  - ONE: simultaneous input and output transfer -> new beat into main reg, stay ONE.
  - FULL: output transfer moves skid to main -> ONE, in_ready=1 next cycle.
  - FULL: in_ready=0, so in_valid is ignored.
- Latency: 1 cycle from input transfer to out_valid when EMPTY. Throughput is 1 beat/cycle while out_ready is held high.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- Stability: out_data, out_op and out_flags hold stable while out_valid=1 and out_ready=0.
- Upstream data change while in_ready=0 has no effect.
- Reset mid-operation discards both entries immediately.

Optional Feature:
- ALU_STICKY_OVF_EN defined:
  - sticky_ovf sets on any output transfer whose overflow flag is 1.
  - It clears on sticky_clr the next cycle.
  - Simultaneous set and clear: set wins.
- ALU_STICKY_OVF_EN undefined: sticky_ovf is constant 0 and sticky_clr is ignored (no register).

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, ...), flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0), state encodings (ST_EMPTY, ST_ONE, ST_FULL).
- One sub-module: alu_flag_gen (combinational zero/negative derivation), reused by the future branch-compare stage.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, in_ready=1, out_flags=0; after release, in_data=16'h0000 with OP_OR -> next cycle out_data=0000, flags=4'b0100.
- Stream of 8 beats 16'h0001..16'h0008 with out_ready=1 -> outputs in order, 1-cycle latency, in_ready stays 1.
- Stall: out_ready=0, send 16'hF0F0 then 16'h0F0F -> out_data holds F0F0 with flags 4'b1000; in_ready=0 after the second beat; release out_ready -> F0F0 then 0F0F, no loss.
- Simultaneous in/out transfer in ONE state, in_data=16'h8000, in_ovf=1, in_carry=1 -> stays ONE; out_flags=4'b1011 next cycle.
- rst_n asserted mid-cycle while FULL -> outputs zero immediately; the first post-reset beat 16'h1234 appears alone.
- ALU_STICKY_OVF_EN: overflow beat accepted -> sticky_ovf=1; sticky_clr pulse -> 0; clr coinciding with a new overflow transfer -> remains 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU result stage and its neighbours.
//   - Opcode tags carried alongside each ALU result.
//   - Bit positions inside the 4-bit flag vector {N, Z, C, V}.
//   - Occupancy-state encoding for the 2-entry result stage.
package alu_pkg;

    // Opcode tags (4-bit encoding of the ALU datapath operations)
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_NOP = 4'hF;

    // Flag vector layout
    localparam int unsigned FLAGW = 4;
    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    // Stage occupancy: how many results are currently held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational zero/negative derivation from a result word.
// Ports:
//   data_i  - result word (WIDTH bits, WIDTH >= 2)
//   zero_o  - 1 when data_i is all zeros
//   neg_o   - sign bit of data_i
module alu_flag_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             zero_o,
    output logic             neg_o
);

    assign zero_o = (data_i == '0);
    assign neg_o  = data_i[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 16-bit ALU datapath.
// Captures result, opcode tag, carry and overflow; derives zero/negative at
// capture; presents {N, Z, C, V} flags with the data over valid/ready.
// A main register plus one skid register absorb a one-cycle consumer stall
// while in_ready stays a pure function of registered state.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid/in_ready           - upstream handshake (in_ready registered)
//   in_data, in_op              - ALU result and its opcode tag
//   in_carry, in_ovf            - adder carry-out / signed overflow
//   out_valid/out_ready         - downstream handshake
//   out_data, out_op, out_flags - registered result, tag, {N, Z, C, V}
//   sticky_clr, sticky_ovf      - sticky overflow clear / status
// Build option: define ALU_STICKY_OVF_EN to implement the sticky overflow
// register; otherwise sticky_ovf is tied low and sticky_clr is ignored.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,  // must be >= 2
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OPW-1:0]   out_op,
    output logic [FLAGW-1:0] out_flags,
    input  logic             sticky_clr,
    output logic             sticky_ovf
);

    alu_state_e state_q, state_d;

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [OPW-1:0]   main_op_q, main_op_d;
    logic [FLAGW-1:0] main_flags_q, main_flags_d;

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [OPW-1:0]   skid_op_q, skid_op_d;
    logic [FLAGW-1:0] skid_flags_q, skid_flags_d;

    logic             in_zero, in_neg;
    logic [FLAGW-1:0] cap_flags;
    logic             in_xfer, out_xfer;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .data_i (in_data),
        .zero_o (in_zero),
        .neg_o  (in_neg)
    );

    always_comb begin
        cap_flags        = '0;
        cap_flags[FLG_N] = in_neg;
        cap_flags[FLG_Z] = in_zero;
        cap_flags[FLG_C] = in_carry;
        cap_flags[FLG_V] = in_ovf;
    end

    // Handshake outputs decode the state register only: no path from out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_op_d    = main_op_q;
        main_flags_d = main_flags_q;
        skid_data_d  = skid_data_q;
        skid_op_d    = skid_op_q;
        skid_flags_d = skid_flags_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_data_d  = in_data;
                    main_op_d    = in_op;
                    main_flags_d = cap_flags;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    // Consumer takes the current beat; replace it in place.
                    main_data_d  = in_data;
                    main_op_d    = in_op;
                    main_flags_d = cap_flags;
                end else if (in_xfer) begin
                    skid_data_d  = in_data;
                    skid_op_d    = in_op;
                    skid_flags_d = cap_flags;
                    state_d      = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_data_d  = skid_data_q;
                    main_op_d    = skid_op_q;
                    main_flags_d = skid_flags_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_op_q    <= '0;
            main_flags_q <= '0;
            skid_data_q  <= '0;
            skid_op_q    <= '0;
            skid_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_op_q    <= main_op_d;
            main_flags_q <= main_flags_d;
            skid_data_q  <= skid_data_d;
            skid_op_q    <= skid_op_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    assign out_data  = main_data_q;
    assign out_op    = main_op_q;
    assign out_flags = main_flags_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Set has priority over clear so a coinciding overflow is never lost.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer && main_flags_q[FLG_V]) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [OPW-1:0]   in_op;
    logic             in_carry;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OPW-1:0]   out_op;
    logic [3:0]       out_flags;
    logic             sticky_clr;
    logic             sticky_ovf;

    int checks = 0;
    int errors = 0;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_on = 1'b1;
`else
    logic sticky_on = 1'b0;
`endif

    alu_result_stage #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_carry   (in_carry),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] op,
                         input logic c, input logic o, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_op     = op;
        in_carry  = c;
        in_ovf    = o;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b1, 16'h5555, OP_ADD, 1'b1, 1'b1, 1'b1);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 16'h0000 || out_op !== 4'h0 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_regs: data=%h op=%h flags=%b, want 0 0 0000",
                     out_data, out_op, out_flags);
        end
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b want 0", sticky_ovf);
        end
        rst_n = 1'b1;
        drive(1'b1, 16'h0000, OP_OR, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_flags !== 4'b0100 ||
            out_op !== OP_OR) begin
            errors++;
            $display("FAIL zero_beat: valid=%b data=%h op=%h flags=%b, want 1 0000 1 0100",
                     out_valid, out_data, out_op, out_flags);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_beat_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), OP_ADD, 1'b0, 1'b0, 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(i) || in_ready !== 1'b1 ||
                out_flags !== 4'b0000) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b flags=%b, want 1 %h 1 0000",
                         i, out_valid, out_data, in_ready, out_flags, 16'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 16'hF0F0, OP_AND, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_data !== 16'hF0F0 || out_flags !== 4'b1000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: data=%h flags=%b ready=%b, want F0F0 1000 1",
                     out_data, out_flags, in_ready);
        end
        drive(1'b1, 16'h0F0F, OP_XOR, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_data !== 16'hF0F0 || out_flags !== 4'b1000 || in_ready !== 1'b0 ||
            out_op !== OP_AND) begin
            errors++;
            $display("FAIL stall_full: data=%h op=%h flags=%b ready=%b, want F0F0 0 1000 0",
                     out_data, out_op, out_flags, in_ready);
        end
        // Upstream changes while blocked must be ignored.
        drive(1'b1, 16'h1111, OP_SUB, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (out_data !== 16'hF0F0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: data=%h ready=%b valid=%b, want F0F0 0 1",
                     out_data, in_ready, out_valid);
        end
        drive(1'b0, 16'h2222, OP_SUB, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0F0F || out_flags !== 4'b0000 ||
            out_op !== OP_XOR || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_second: valid=%b data=%h op=%h flags=%b ready=%b, want 1 0F0F 2 0000 1",
                     out_valid, out_data, out_op, out_flags, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: valid=%b want 0 (no duplicate)", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 16'h0005, OP_ADD, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h8000, OP_SUB, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_flags !== 4'b1011 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_replace: valid=%b data=%h flags=%b ready=%b, want 1 8000 1011 1",
                     out_valid, out_data, out_flags, in_ready);
        end
        drive(1'b0, 16'h0000, OP_NOP, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_flags !== 4'b1011) begin
            errors++;
            $display("FAIL simul_stable: valid=%b data=%h flags=%b, want 1 8000 1011",
                     out_valid, out_data, out_flags);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'hAAAA, OP_OR, 1'b0, 1'b0, 1'b0);
        step();
        in_data = 16'hBBBB;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: ready=%b want 0", in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000 ||
            out_flags !== 4'b0000 || sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b data=%h flags=%b sticky=%b, want 0 1 0000 0000 0",
                     out_valid, in_ready, out_data, out_flags, sticky_ovf);
        end
        step();
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, OP_ADD, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL mid_first: valid=%b data=%h flags=%b, want 1 1234 0000",
                     out_valid, out_data, out_flags);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_alone: valid=%b data=%h, want valid 0", out_valid, out_data);
        end
    endtask

    task automatic test_sticky();
        // Overflow beat accepted by the consumer sets sticky (when built in).
        drive(1'b1, 16'h7FFF, OP_ADD, 1'b0, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sticky_early: got %b want 0", sticky_ovf);
        end
        step();
        checks++;
        if (sticky_ovf !== sticky_on) begin
            errors++;
            $display("FAIL sticky_set: got %b want %b", sticky_ovf, sticky_on);
        end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b want 0", sticky_ovf);
        end
        drive(1'b1, 16'h8001, OP_SUB, 1'b1, 1'b1, 1'b1);
        step();
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_ovf !== sticky_on) begin
            errors++;
            $display("FAIL sticky_set_wins: got %b want %b", sticky_ovf, sticky_on);
        end
    endtask

    initial begin
        drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_stall();
        test_simultaneous();
        test_reset_mid();
        test_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
